// File: rtl/ber_checker_pkg.sv
// Shared definitions for the receive-side BER checker: FSM encoding and
// defaults common with the TX chain.
package ber_checker_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  localparam int NBT_IN_DEFAULT = 8;
  localparam int OS_DEFAULT     = 4;

  // Period of the TX PRBS; also the natural reference depth and sync length.
  localparam int PRBS_PERIOD = 511;

endpackage

// File: rtl/ber_checker_ref_delay_line.sv
// TX reference delay line: shifts in one bit per symbol strobe and exposes
// an arbitrary tap for the delay search.
module ber_checker_ref_delay_line
  import ber_checker_pkg::*;
#(
  parameter int NBUF = PRBS_PERIOD,
  parameter int DW   = $clog2(NBUF)
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_shift,
  input  logic          i_bit,
  input  logic [DW-1:0] i_sel,
  output logic          o_bit
);

  logic [NBUF-1:0] line;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      line <= '0;
    end else if (i_shift) begin
      line <= {line[NBUF-2:0], i_bit};
    end
  end

  assign o_bit = line[i_sel];

endmodule

// File: rtl/ber_checker.sv
// Decimates and slices one QPSK branch, finds the reference alignment by
// exhaustive delay search, then counts bit errors once locked.
module ber_checker
  import ber_checker_pkg::*;
#(
  parameter int NBT_IN = NBT_IN_DEFAULT,
  parameter int OS     = OS_DEFAULT,
  parameter int NBUF   = PRBS_PERIOD,
  parameter int NSYNC  = PRBS_PERIOD,
  parameter int NB_CNT = 64
) (
  input  logic                    clk,
  input  logic                    i_reset,
  input  logic [NBT_IN-1:0]       i_os_data,
  input  logic [$clog2(OS)-1:0]   i_phase_num,
  input  logic [$clog2(OS)-1:0]   i_phase_sel,
  input  logic                    i_ctrl,
  input  logic                    i_ref_bit,
  input  logic                    i_enable,
  output logic                    o_locked,
  output logic [$clog2(NBUF)-1:0] o_best_delay,
  output logic [NB_CNT-1:0]       o_err_count,
  output logic [NB_CNT-1:0]       o_bit_count
);

  localparam int DW = $clog2(NBUF);
  localparam int CW = $clog2(NSYNC);
  localparam int EW = $clog2(NSYNC + 1);

  logic              samp;
  logic              cmp_strobe;
  logic              rx_bit;
  logic              ref_sel;
  logic              ref_tap;
  logic              err_bit;
  logic [1:0]        state;
  logic [DW-1:0]     delay;
  logic [DW-1:0]     best_delay;
  logic [EW-1:0]     sync_err;
  logic [EW-1:0]     best_err;
  logic [EW-1:0]     sync_total;
  logic              take_best;
  logic [CW-1:0]     sync_cnt;
  logic [NB_CNT-1:0] err_count;
  logic [NB_CNT-1:0] bit_count;
  logic              unused_data;

  assign samp        = (i_phase_num == i_phase_sel) && i_enable;
  assign err_bit     = rx_bit ^ ref_sel;
  assign sync_total  = sync_err + EW'(err_bit);
  assign take_best   = sync_total < best_err;
  assign unused_data = ^i_os_data[NBT_IN-2:0];

  ber_checker_ref_delay_line #(
    .NBUF (NBUF),
    .DW   (DW)
  ) u_ref_delay_line (
    .clk     (clk),
    .i_reset (i_reset),
    .i_shift (i_ctrl),
    .i_bit   (i_ref_bit),
    .i_sel   (delay),
    .o_bit   (ref_tap)
  );

  // The reference tap is captured with the sample so a coincident symbol
  // strobe compares against the line before it shifts.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      rx_bit     <= 1'b0;
      ref_sel    <= 1'b0;
      cmp_strobe <= 1'b0;
    end else begin
      cmp_strobe <= samp;
      if (samp) begin
        rx_bit  <= i_os_data[NBT_IN-1];
        ref_sel <= ref_tap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset || !i_enable) begin
      state      <= ST_IDLE;
      delay      <= '0;
      best_delay <= '0;
      best_err   <= '1;
      sync_err   <= '0;
      sync_cnt   <= '0;
      err_count  <= '0;
      bit_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_SYNC;
        ST_SYNC: begin
          if (cmp_strobe) begin
            if (sync_cnt == CW'(NSYNC - 1)) begin
              sync_cnt <= '0;
              sync_err <= '0;
              if (take_best) begin
                best_err   <= sync_total;
                best_delay <= delay;
              end
              // Last candidate may itself be the winner, so pick from take_best.
              if (delay == DW'(NBUF - 1)) begin
                delay <= take_best ? delay : best_delay;
                state <= ST_LOCK;
              end else begin
                delay <= delay + DW'(1);
              end
            end else begin
              sync_cnt <= sync_cnt + CW'(1);
              sync_err <= sync_total;
            end
          end
        end
        ST_LOCK: begin
          if (cmp_strobe) begin
            if (bit_count != '1) begin
              bit_count <= bit_count + NB_CNT'(1);
            end
            if (err_bit && (err_count != '1)) begin
              err_count <= err_count + NB_CNT'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_locked     = (state == ST_LOCK);
  assign o_best_delay = best_delay;
  assign o_err_count  = err_count;
  assign o_bit_count  = bit_count;

endmodule

// File: tb/tb_ber_checker.sv
// Randomized bench for ber_checker: drives symbol streams and checks against
// a compare-list reference model of sync search and locked counting.
module tb_ber_checker;

  localparam int NBT    = 8;
  localparam int OS     = 4;
  localparam int NBUF   = 15;
  localparam int NSYNC  = 15;
  localparam int NB_CNT = 8;
  localparam int SYNC_LEN = NBUF * NSYNC;

  logic              clk = 1'b0;
  logic              i_reset = 1'b0;
  logic [NBT-1:0]    i_os_data = '0;
  logic [1:0]        i_phase_num = '0;
  logic [1:0]        i_phase_sel = '0;
  logic              i_ctrl = 1'b0;
  logic              i_ref_bit = 1'b0;
  logic              i_enable = 1'b0;
  logic              o_locked;
  logic [3:0]        o_best_delay;
  logic [NB_CNT-1:0] o_err_count;
  logic [NB_CNT-1:0] o_bit_count;

  ber_checker #(
    .NBT_IN (NBT),
    .OS     (OS),
    .NBUF   (NBUF),
    .NSYNC  (NSYNC),
    .NB_CNT (NB_CNT)
  ) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_os_data    (i_os_data),
    .i_phase_num  (i_phase_num),
    .i_phase_sel  (i_phase_sel),
    .i_ctrl       (i_ctrl),
    .i_ref_bit    (i_ref_bit),
    .i_enable     (i_enable),
    .o_locked     (o_locked),
    .o_best_delay (o_best_delay),
    .o_err_count  (o_err_count),
    .o_bit_count  (o_bit_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int sym_idx = 0;
  int cur_sel = 0;
  bit pat [512];

  // Reference model state: history of reference bits and one entry per compare.
  bit              ref_hist[$];
  bit              cmp_rx[$];
  logic [NBUF-1:0] cmp_snap[$];

  logic              exp_locked;
  logic [3:0]        exp_best;
  logic [NB_CNT-1:0] exp_err;
  logic [NB_CNT-1:0] exp_bits;

  function automatic logic [7:0] slice_val(input bit b);
    int m;
    if (b) begin
      m = $urandom_range(128, 1);
      return 8'(-m);
    end
    if ($urandom_range(7, 0) == 0) return 8'd0;
    return 8'($urandom_range(127, 1));
  endfunction

  task automatic drive_cycle(input logic rst, input logic en, input logic [1:0] ph,
                             input logic ctrl, input logic refb, input logic [7:0] data);
    logic [NBUF-1:0] snap;
    @(posedge clk);
    #1;
    i_reset     = rst;
    i_enable    = en;
    i_phase_num = ph;
    i_phase_sel = 2'(cur_sel);
    i_ctrl      = ctrl;
    i_ref_bit   = refb;
    i_os_data   = data;
    if (rst) begin
      ref_hist.delete();
      cmp_rx.delete();
      cmp_snap.delete();
    end else begin
      if (!en) begin
        cmp_rx.delete();
        cmp_snap.delete();
      end else if (int'(ph) == cur_sel) begin
        snap = '0;
        for (int d = 0; d < NBUF; d++)
          if (d < ref_hist.size()) snap[d] = ref_hist[ref_hist.size() - 1 - d];
        cmp_rx.push_back(data[7]);
        cmp_snap.push_back(snap);
      end
      if (ctrl) ref_hist.push_back(refb);
    end
  endtask

  task automatic freeze_cycle();
    drive_cycle(1'b0, 1'b1, 2'((cur_sel + 1) % OS), 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic restart(input int sel);
    cur_sel = sel;
    sym_idx = 0;
    drive_cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
    drive_cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic run_symbols(input int count, input int dly, input int peak, input int last_ph,
                             input int flip_every, input bit invert);
    for (int k = 0; k < count; k++) begin
      bit refb;
      bit rxb;
      refb = pat[sym_idx % 512];
      rxb  = (sym_idx >= dly) ? pat[(sym_idx - dly) % 512] : 1'b0;
      if (flip_every > 0 && (k % flip_every) == 0) rxb = ~rxb;
      if (invert) rxb = ~rxb;
      for (int ph = 0; ph <= last_ph; ph++)
        drive_cycle(1'b0, 1'b1, 2'(ph), ph == 0, refb,
                    (ph == peak) ? slice_val(rxb) : 8'($urandom));
      sym_idx++;
    end
  endtask

  // Sync: compare j belongs to candidate j/NSYNC; first strict minimum wins.
  // Lock: every later compare counts against the winning tap, saturating.
  task automatic model_expect();
    int errs[NBUF];
    int best;
    int e;
    int b;
    for (int c = 0; c < NBUF; c++) errs[c] = 0;
    for (int j = 0; j < cmp_rx.size() && j < SYNC_LEN; j++)
      errs[j / NSYNC] += int'(cmp_rx[j] ^ cmp_snap[j][j / NSYNC]);
    best = 0;
    for (int c = 1; c < NBUF; c++) if (errs[c] < errs[best]) best = c;
    e = 0;
    b = 0;
    for (int j = SYNC_LEN; j < cmp_rx.size(); j++) begin
      b++;
      e += int'(cmp_rx[j] ^ cmp_snap[j][best]);
    end
    exp_locked = (cmp_rx.size() >= SYNC_LEN);
    exp_best   = 4'(best);
    exp_err    = (e > 255) ? 8'd255 : 8'(e);
    exp_bits   = (b > 255) ? 8'd255 : 8'(b);
  endtask

  task automatic test_reset();
    restart(2);
    n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_locked: got %0b want 0", o_locked); end
    n_cmp++; if (o_best_delay !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_best: got %0d want 0", o_best_delay); end
    n_cmp++; if (o_err_count !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_err: got %0d want 0", o_err_count); end
    n_cmp++; if (o_bit_count !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_bits: got %0d want 0", o_bit_count); end
  endtask

  task automatic test_sync_lock();
    restart(2);
    run_symbols(SYNC_LEN - 1, 5, 2, OS - 1, 0, 1'b0);
    run_symbols(1, 5, 2, 2, 0, 1'b0);
    freeze_cycle();
    n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("[TB] FAIL lock_early: got %0b want 0", o_locked); end
    freeze_cycle();
    model_expect();
    n_cmp++; if (o_locked !== 1'b1) begin n_fail++; $display("[TB] FAIL lock_rise: got %0b want 1", o_locked); end
    n_cmp++; if (o_best_delay !== exp_best) begin n_fail++; $display("[TB] FAIL lock_best_model: got %0d want %0d", o_best_delay, exp_best); end
    n_cmp++; if (o_best_delay !== 4'd5) begin n_fail++; $display("[TB] FAIL lock_best_delay: got %0d want 5", o_best_delay); end
    run_symbols(40, 5, 2, OS - 1, 0, 1'b0);
    freeze_cycle();
    freeze_cycle();
    model_expect();
    n_cmp++; if (o_err_count !== 8'd0) begin n_fail++; $display("[TB] FAIL clean_err: got %0d want 0", o_err_count); end
    n_cmp++; if (o_bit_count !== exp_bits) begin n_fail++; $display("[TB] FAIL clean_bits: got %0d want %0d", o_bit_count, exp_bits); end
  endtask

  task automatic test_latency();
    logic [NB_CNT-1:0] prev;
    model_expect();
    prev = exp_bits;
    run_symbols(1, 5, 2, 2, 0, 1'b0);
    freeze_cycle();
    n_cmp++; if (o_bit_count !== prev) begin n_fail++; $display("[TB] FAIL latency_hold: got %0d want %0d", o_bit_count, prev); end
    freeze_cycle();
    n_cmp++; if (o_bit_count !== prev + 8'd1) begin n_fail++; $display("[TB] FAIL latency_update: got %0d want %0d", o_bit_count, prev + 8'd1); end
  endtask

  task automatic test_error_inject();
    run_symbols(100, 5, 2, OS - 1, 10, 1'b0);
    freeze_cycle();
    freeze_cycle();
    model_expect();
    n_cmp++; if (o_err_count !== exp_err) begin n_fail++; $display("[TB] FAIL inject_err: got %0d want %0d", o_err_count, exp_err); end
    n_cmp++; if (o_bit_count !== exp_bits) begin n_fail++; $display("[TB] FAIL inject_bits: got %0d want %0d", o_bit_count, exp_bits); end
  endtask

  task automatic test_delay_offset();
    restart(1);
    run_symbols(SYNC_LEN + 20, 12, 1, OS - 1, 0, 1'b0);
    freeze_cycle();
    freeze_cycle();
    model_expect();
    n_cmp++; if (o_locked !== 1'b1) begin n_fail++; $display("[TB] FAIL offset_locked: got %0b want 1", o_locked); end
    n_cmp++; if (o_best_delay !== 4'd12) begin n_fail++; $display("[TB] FAIL offset_best: got %0d want 12", o_best_delay); end
    n_cmp++; if (o_err_count !== 8'd0) begin n_fail++; $display("[TB] FAIL offset_err: got %0d want 0", o_err_count); end
  endtask

  task automatic test_coincide();
    restart(0);
    run_symbols(SYNC_LEN + 20, 4, 0, OS - 1, 0, 1'b0);
    freeze_cycle();
    freeze_cycle();
    model_expect();
    n_cmp++; if (o_best_delay !== exp_best) begin n_fail++; $display("[TB] FAIL coincide_best_model: got %0d want %0d", o_best_delay, exp_best); end
    n_cmp++; if (o_best_delay !== 4'd3) begin n_fail++; $display("[TB] FAIL coincide_best: got %0d want 3", o_best_delay); end
    n_cmp++; if (o_err_count !== exp_err) begin n_fail++; $display("[TB] FAIL coincide_err: got %0d want %0d", o_err_count, exp_err); end
  endtask

  task automatic test_phase_change();
    cur_sel = 2;
    run_symbols(30, 4, 2, OS - 1, 0, 1'b0);
    freeze_cycle();
    freeze_cycle();
    model_expect();
    n_cmp++; if (o_locked !== 1'b1) begin n_fail++; $display("[TB] FAIL phase_locked: got %0b want 1", o_locked); end
    n_cmp++; if (o_err_count !== exp_err) begin n_fail++; $display("[TB] FAIL phase_err: got %0d want %0d", o_err_count, exp_err); end
    n_cmp++; if (o_bit_count !== exp_bits) begin n_fail++; $display("[TB] FAIL phase_bits: got %0d want %0d", o_bit_count, exp_bits); end
  endtask

  task automatic test_wrong_phase();
    restart(3);
    run_symbols(SYNC_LEN + 20, 5, 1, OS - 1, 0, 1'b0);
    freeze_cycle();
    freeze_cycle();
    model_expect();
    n_cmp++; if (o_locked !== 1'b1) begin n_fail++; $display("[TB] FAIL wrong_locked: got %0b want 1", o_locked); end
    n_cmp++; if (o_best_delay !== exp_best) begin n_fail++; $display("[TB] FAIL wrong_best: got %0d want %0d", o_best_delay, exp_best); end
    n_cmp++; if (o_err_count !== exp_err) begin n_fail++; $display("[TB] FAIL wrong_err: got %0d want %0d", o_err_count, exp_err); end
    n_cmp++; if (o_err_count == 8'd0) begin n_fail++; $display("[TB] FAIL wrong_err_nonzero: got %0d want >0", o_err_count); end
  endtask

  task automatic test_reset_mid_sync();
    restart(2);
    run_symbols(100, 6, 2, OS - 1, 0, 1'b0);
    drive_cycle(1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 8'hC0);
    freeze_cycle();
    n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_locked: got %0b want 0", o_locked); end
    n_cmp++; if (o_best_delay !== 4'd0) begin n_fail++; $display("[TB] FAIL midrst_best: got %0d want 0", o_best_delay); end
    n_cmp++; if (o_err_count !== 8'd0) begin n_fail++; $display("[TB] FAIL midrst_err: got %0d want 0", o_err_count); end
    n_cmp++; if (o_bit_count !== 8'd0) begin n_fail++; $display("[TB] FAIL midrst_bits: got %0d want 0", o_bit_count); end
    restart(2);
    run_symbols(SYNC_LEN + 10, 6, 2, OS - 1, 0, 1'b0);
    freeze_cycle();
    freeze_cycle();
    model_expect();
    n_cmp++; if (o_best_delay !== 4'd6) begin n_fail++; $display("[TB] FAIL resync_best: got %0d want 6", o_best_delay); end
    n_cmp++; if (o_bit_count !== exp_bits) begin n_fail++; $display("[TB] FAIL resync_bits: got %0d want %0d", o_bit_count, exp_bits); end
  endtask

  task automatic test_saturation();
    restart(2);
    run_symbols(SYNC_LEN, 5, 2, OS - 1, 0, 1'b0);
    run_symbols(300, 5, 2, OS - 1, 0, 1'b1);
    freeze_cycle();
    freeze_cycle();
    model_expect();
    n_cmp++; if (o_err_count !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_err: got %0d want 255", o_err_count); end
    n_cmp++; if (o_bit_count !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_bits: got %0d want 255", o_bit_count); end
    n_cmp++; if (o_err_count !== exp_err) begin n_fail++; $display("[TB] FAIL sat_err_model: got %0d want %0d", o_err_count, exp_err); end
  endtask

  task automatic test_disable();
    drive_cycle(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 8'h80);
    freeze_cycle();
    n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("[TB] FAIL disable_locked: got %0b want 0", o_locked); end
    n_cmp++; if (o_best_delay !== 4'd0) begin n_fail++; $display("[TB] FAIL disable_best: got %0d want 0", o_best_delay); end
    n_cmp++; if (o_err_count !== 8'd0) begin n_fail++; $display("[TB] FAIL disable_err: got %0d want 0", o_err_count); end
    n_cmp++; if (o_bit_count !== 8'd0) begin n_fail++; $display("[TB] FAIL disable_bits: got %0d want 0", o_bit_count); end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 512; i++) pat[i] = 1'($urandom);
    $display("[TB] starting ber_checker bench");
    test_reset();
    test_sync_lock();
    test_latency();
    test_error_inject();
    test_delay_offset();
    test_coincide();
    test_phase_change();
    test_wrong_phase();
    test_reset_mid_sync();
    test_saturation();
    test_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
